// File: rtl/bram_rd_streamer_pkg.sv
// Shared constants for the BRAM read streamer: default BRAM geometry and FSM encodings.
package bram_rd_streamer_pkg;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_MEM_WIDTH  = 16;
  localparam int DEF_MEM_DEPTH  = 3840;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/bram_rd_streamer_if.sv
// BRAM port plus output valid/ready stream; master = streamer side, slave = BRAM/consumer side.
interface bram_rd_streamer_if
  import bram_rd_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH
) ();
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_ce_o;
  logic                  mem_we_o;
  logic [MEM_WIDTH-1:0]  mem_d_o;
  logic [MEM_WIDTH-1:0]  mem_q_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [MEM_WIDTH-1:0]  m_data_o;

  modport master (
    output mem_addr_o, mem_ce_o, mem_we_o, mem_d_o, m_valid_o, m_data_o,
    input  mem_q_i, m_ready_i
  );
  modport slave (
    input  mem_addr_o, mem_ce_o, mem_we_o, mem_d_o, m_valid_o, m_data_o,
    output mem_q_i, m_ready_i
  );
endinterface

// File: rtl/bram_rd_streamer_rd_skid_fifo.sv
// 2-entry valid/ready FIFO with registered head and occupancy output.
// The writer is responsible for never pushing while full.
module rd_skid_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_wr_valid,
  input  logic [W-1:0] i_wr_data,
  output logic         o_rd_valid,
  input  logic         i_rd_ready,
  output logic [W-1:0] o_rd_data,
  output logic [1:0]   o_count
);
  logic [1:0][W-1:0] r_mem;
  logic              r_wptr, r_rptr;
  logic [1:0]        r_count;
  logic              w_pop;

  assign w_pop      = (r_count != 2'd0) && i_rd_ready;
  assign o_rd_valid = (r_count != 2'd0);
  assign o_rd_data  = r_mem[r_rptr];
  assign o_count    = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem   <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_wr_valid) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, i_wr_valid} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/bram_rd_streamer.sv
// Streams a contiguous (wrapping) run of BRAM words out as valid/ready, hiding the 1-cycle read latency.
// Optional BRAM_RD_STRIDE_EN adds stride_i: address advances by a latched stride modulo MEM_DEPTH.
module bram_rd_streamer
  import bram_rd_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
`ifdef BRAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
  output logic                  idle_o,
  output logic                  done_o,
  bram_rd_streamer_if.master    bus
);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_stride;
  logic [ADDR_WIDTH:0]   r_len, r_issued;
  logic                  r_inflight;

  logic                  w_start, w_issue, w_pop, w_drain_done;
  logic [1:0]            w_count;
  logic [2:0]            w_credit;
  logic [ADDR_WIDTH:0]   w_addr_sum, w_issued_inc;
  logic [ADDR_WIDTH-1:0] w_addr_next, w_stride_in;

`ifdef BRAM_RD_STRIDE_EN
  assign w_stride_in = stride_i;
`else
  assign w_stride_in = ADDR_WIDTH'(1);
`endif

  // DONE doubles as the last idle cycle: it carries the done pulse and already accepts a new start.
  assign idle_o  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign done_o  = (r_state == ST_DONE);
  assign w_start = start_i && idle_o;

  // Credit counts words already buffered plus the one in flight, minus the one leaving now.
  assign w_pop    = bus.m_valid_o && bus.m_ready_i;
  assign w_credit = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue  = (r_state == ST_RUN) && (r_issued != r_len) && (w_credit < 3'd2);

  assign w_issued_inc = r_issued + LP_ONE;
  assign w_addr_sum   = {1'b0, r_addr} + {1'b0, r_stride};
  assign w_addr_next  = (w_addr_sum >= LP_DEPTH) ? ADDR_WIDTH'(w_addr_sum - LP_DEPTH)
                                                 : ADDR_WIDTH'(w_addr_sum);

  // Leave DRAIN as soon as the FIFO empties this cycle, so done lands right after the last word.
  assign w_drain_done = !r_inflight && (w_count == {1'b0, w_pop});

  assign bus.mem_addr_o = r_addr;
  assign bus.mem_ce_o   = w_issue;
  assign bus.mem_we_o   = 1'b0;
  assign bus.mem_d_o    = '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_stride   <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_addr   <= base_addr_i;
            r_len    <= len_i;
            r_stride <= w_stride_in;
            r_issued <= '0;
            r_state  <= (len_i == '0) ? ST_DONE : ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_addr   <= w_addr_next;
            r_issued <= w_issued_inc;
            if (w_issued_inc == r_len) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (w_drain_done) r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  rd_skid_fifo #(.W(MEM_WIDTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_wr_valid (r_inflight),
    .i_wr_data  (bus.mem_q_i),
    .o_rd_valid (bus.m_valid_o),
    .i_rd_ready (bus.m_ready_i),
    .o_rd_data  (bus.m_data_o),
    .o_count    (w_count)
  );
endmodule
